// File: rtl/util_pkg.sv
// Shared types and helpers for pulse stretching and clock-division blocks.
package util_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN} stretch_state_t;

    // Clocks per tick, clamped so a misconfigured ratio still yields a working divider.
    function automatic int unsigned calc_div(input int unsigned clkfreq, input int unsigned tickfreq);
        int unsigned d;
        d = clkfreq / tickfreq;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for the one cycle the count holds DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 10,
    parameter int unsigned W   = $clog2(DIV) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pulse_to_level.sv
// Stretches an accepted trigger pulse into a level held for a number of prescaled ticks,
// optionally followed by a cooldown during which new triggers are ignored.
module pulse_to_level
    import util_pkg::*;
#(
    parameter int unsigned CLKFREQ     = 100_000_000,
    parameter int unsigned TICKFREQ    = 1000,
    parameter int          CNTBITS     = 16,
    parameter int unsigned HOLD_TICKS  = 500,
    parameter int unsigned GUARD_TICKS = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               cancel,
    input  logic               retrigger_en,
    input  logic [CNTBITS-1:0] hold_ticks,
    output logic               level,
    output logic               ready,
    output logic               done,
    output logic [CNTBITS-1:0] remaining
);

    localparam int unsigned        DIV      = calc_div(CLKFREQ, TICKFREQ);
    localparam logic [CNTBITS-1:0] HOLD_LD  = CNTBITS'(HOLD_TICKS);
    localparam logic [CNTBITS-1:0] GUARD_LD = CNTBITS'(GUARD_TICKS);
    localparam logic [CNTBITS-1:0] ONE      = CNTBITS'(1);

    stretch_state_t     state, state_nx;
    logic [CNTBITS-1:0] remaining_nx;
    logic               done_nx;
    logic               accept;
    logic               tick;

    // Clearing the prescaler on acceptance makes the hold cycle-exact from the trigger edge.
    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        done_nx      = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) accept = 1'b1;
            end
            HOLD: begin
                if (cancel) begin
                    state_nx     = IDLE;
                    remaining_nx = '0;
                end else if (trigger && retrigger_en) begin
                    accept = 1'b1;
                end else if (tick) begin
                    if (remaining == ONE) begin
                        done_nx = 1'b1;
                        if (GUARD_TICKS > 0) begin
                            state_nx     = COOLDOWN;
                            remaining_nx = GUARD_LD;
                        end else begin
                            state_nx     = IDLE;
                            remaining_nx = '0;
                        end
                    end else begin
                        remaining_nx = remaining - ONE;
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (remaining == ONE) begin
                        state_nx     = IDLE;
                        remaining_nx = '0;
                    end else begin
                        remaining_nx = remaining - ONE;
                    end
                end
            end
            default: begin
                state_nx     = IDLE;
                remaining_nx = '0;
            end
        endcase
        if (accept) begin
            state_nx     = HOLD;
            remaining_nx = (hold_ticks == '0) ? HOLD_LD : hold_ticks;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            done      <= done_nx;
        end
    end

    assign level = (state == HOLD);
    assign ready = (state == IDLE);

endmodule

// File: tb/tb_pulse_to_level.sv
// Self-checking bench for pulse_to_level with DIV=10, HOLD_TICKS=3, GUARD_TICKS=2, CNTBITS=8.
module tb_pulse_to_level;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic       cancel = 1'b0;
    logic       retrigger_en = 1'b0;
    logic [7:0] hold_ticks = 8'd0;
    logic       level;
    logic       ready;
    logic       done;
    logic [7:0] remaining;

    pulse_to_level #(
        .CLKFREQ(100), .TICKFREQ(10), .CNTBITS(8), .HOLD_TICKS(3), .GUARD_TICKS(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trigger      (trigger),
        .cancel       (cancel),
        .retrigger_en (retrigger_en),
        .hold_ticks   (hold_ticks),
        .level        (level),
        .ready        (ready),
        .done         (done),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Scoreboard of expected level pulses: length in cycles and whether done marks the end.
    typedef struct {
        int    len;
        bit    done_exp;
        string tag;
    } sb_t;
    sb_t sb_q[$];
    int  exp_dones  = 0;
    int  dones_seen = 0;
    int  run_len    = 0;
    bit  prev_level = 1'b0;

    task automatic expect_pulse(input int len, input bit d, input string tag);
        sb_t e;
        e.len      = len;
        e.done_exp = d;
        e.tag      = tag;
        sb_q.push_back(e);
        if (d) exp_dones++;
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (done) dones_seen++;
        if (level) begin
            run_len++;
        end else if (prev_level) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse of %0d cycles, required none", run_len);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, " level_len"}, run_len, e.len);
                check({e.tag, " done_at_end"}, int'(done), int'(e.done_exp));
            end
            run_len = 0;
        end
        prev_level = level;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input int hold, input bit rt, input int cyc, input bit cxl);
        trigger      = 1'b1;
        hold_ticks   = 8'(hold);
        retrigger_en = rt;
        cancel       = cxl;
        repeat (cyc) step();
        trigger = 1'b0;
        cancel  = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int busy);
        bit ok;
        ok   = 1'b0;
        busy = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (ready) ok = 1'b1;
            else busy++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s wait_ready: got ready=0 after 400 cycles, required ready=1", tag);
        end
    endtask

    typedef struct {
        int hold;
        bit rt;
        int cyc;
        bit cxl;
        int exp_len;
        bit exp_done;
        int exp_busy;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int busy;
        string tag;

        // busy counts ready-low cycles seen after the trigger is released
        vecs[0] = '{hold: 0, rt: 0, cyc: 1, cxl: 0, exp_len: 30, exp_done: 1, exp_busy: 50};
        vecs[1] = '{hold: 5, rt: 0, cyc: 2, cxl: 0, exp_len: 50, exp_done: 1, exp_busy: 69};
        vecs[2] = '{hold: 1, rt: 0, cyc: 1, cxl: 0, exp_len: 10, exp_done: 1, exp_busy: 30};
        vecs[3] = '{hold: 5, rt: 1, cyc: 2, cxl: 0, exp_len: 51, exp_done: 1, exp_busy: 70};
        vecs[4] = '{hold: 2, rt: 0, cyc: 1, cxl: 1, exp_len: 20, exp_done: 1, exp_busy: 40};
        vecs[5] = '{hold: 0, rt: 1, cyc: 1, cxl: 0, exp_len: 30, exp_done: 1, exp_busy: 50};

        repeat (2) @(posedge clk);
        #1;
        check("reset level", int'(level), 0);
        check("reset ready", int'(ready), 1);
        check("reset done", int'(done), 0);
        check("reset remaining", int'(remaining), 0);
        reset = 1'b0;
        repeat (4) step();

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            expect_pulse(vecs[i].exp_len, vecs[i].exp_done, tag);
            fire(vecs[i].hold, vecs[i].rt, vecs[i].cyc, vecs[i].cxl);
            wait_ready(tag, busy);
            check({tag, " busy_cycles"}, busy, vecs[i].exp_busy);
            check({tag, " remaining_idle"}, int'(remaining), 0);
            step();
        end

        // retrigger 25 cycles into a hold
        expect_pulse(55, 1'b1, "retrig_on");
        fire(0, 1'b1, 1, 1'b0);
        repeat (24) step();
        fire(0, 1'b1, 1, 1'b0);
        wait_ready("retrig_on", busy);
        check("retrig_on busy_cycles", busy, 50);
        step();

        expect_pulse(30, 1'b1, "retrig_off");
        fire(0, 1'b0, 1, 1'b0);
        repeat (24) step();
        fire(0, 1'b0, 1, 1'b0);
        wait_ready("retrig_off", busy);
        check("retrig_off busy_cycles", busy, 25);
        step();

        // cancel together with trigger 12 cycles into a hold
        expect_pulse(12, 1'b0, "cancel");
        fire(0, 1'b0, 1, 1'b0);
        repeat (11) step();
        fire(0, 1'b0, 1, 1'b1);
        @(negedge clk);
        check("cancel level", int'(level), 0);
        check("cancel ready", int'(ready), 1);
        check("cancel remaining", int'(remaining), 0);
        check("cancel done", int'(done), 0);
        repeat (5) @(negedge clk);
        check("cancel no_cooldown", int'(ready), 1);
        step();

        // trigger during cooldown is dropped
        expect_pulse(10, 1'b1, "cool_ign");
        fire(1, 1'b0, 1, 1'b0);
        repeat (14) step();
        fire(0, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("cool_ign level", int'(level), 0);
        check("cool_ign ready", int'(ready), 0);
        wait_ready("cool_ign", busy);
        check("cool_ign busy_cycles", busy, 14);
        repeat (3) @(negedge clk);
        check("cool_ign level_after", int'(level), 0);
        step();

        // expiry tick coincides with trigger, retrigger enabled
        expect_pulse(60, 1'b1, "exp_retrig");
        fire(0, 1'b1, 1, 1'b0);
        repeat (29) step();
        @(negedge clk);
        check("exp_retrig remaining_last", int'(remaining), 1);
        fire(0, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("exp_retrig level", int'(level), 1);
        check("exp_retrig done", int'(done), 0);
        check("exp_retrig remaining", int'(remaining), 3);
        wait_ready("exp_retrig", busy);
        check("exp_retrig busy_cycles", busy, 49);
        step();

        // expiry tick coincides with trigger, retrigger disabled
        expect_pulse(30, 1'b1, "exp_noretrig");
        fire(0, 1'b0, 1, 1'b0);
        repeat (29) step();
        @(negedge clk);
        fire(0, 1'b0, 1, 1'b0);
        @(negedge clk);
        check("exp_noretrig level", int'(level), 0);
        check("exp_noretrig done", int'(done), 1);
        check("exp_noretrig ready", int'(ready), 0);
        check("exp_noretrig remaining", int'(remaining), 2);
        wait_ready("exp_noretrig", busy);
        check("exp_noretrig busy_cycles", busy, 19);
        step();

        // asynchronous reset mid-hold, between clock edges
        expect_pulse(15, 1'b0, "async_rst");
        fire(0, 1'b0, 1, 1'b0);
        repeat (14) step();
        #6;
        reset = 1'b1;
        #1;
        check("async_rst level", int'(level), 0);
        check("async_rst ready", int'(ready), 1);
        check("async_rst remaining", int'(remaining), 0);
        check("async_rst done", int'(done), 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        expect_pulse(30, 1'b1, "post_rst");
        fire(0, 1'b0, 1, 1'b0);
        wait_ready("post_rst", busy);
        check("post_rst busy_cycles", busy, 50);

        repeat (5) step();
        check("scoreboard_empty", sb_q.size(), 0);
        check("done_pulse_total", dones_seen, exp_dones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
- Converts a one-cycle request pulse into a timed active-high level, for example a door-unlock strobe or an alarm enable.
- The hold time is counted in prescaled ticks, followed by an optional cooldown lockout.
- Sits downstream of the keypad and passcode logic: accepted-code pulse in, actuator level out.
- Includes its own tick prescaler, so the hold duration is cycle-exact relative to the accepted trigger.

Parameters:
- CLKFREQ, 100_000_000: input clock frequency in Hz.
- TICKFREQ, 1000: tick rate in Hz. DIV = CLKFREQ/TICKFREQ, required >= 1.
- CNTBITS, 16: width of the tick counters and the hold_ticks port.
- HOLD_TICKS, 500: default hold length in ticks. Used when the hold_ticks input is 0. Required 1..2^CNTBITS-1.
- GUARD_TICKS, 0: cooldown length in ticks after a natural expiry. 0 means no cooldown.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- trigger, input, 1: request pulse, sampled each rising edge. Width above one cycle is allowed; each high cycle counts as a request.
- cancel, input, 1: abort the hold. Level drops, no done pulse.
- retrigger_en, input, 1: 1 means a trigger during HOLD reloads the count.
- hold_ticks, input, CNTBITS: hold length, sampled on each accepted trigger. 0 selects HOLD_TICKS.
- level, output, 1: stretched output level.
- ready, output, 1: high only in IDLE.
- done, output, 1: one-cycle pulse on natural expiry.
- remaining, output, CNTBITS: ticks left in the current HOLD or COOLDOWN; 0 in IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is asserted: state=IDLE, level=0, ready=1, done=0, remaining=0, prescaler=0. These values take effect immediately, not at the next edge.
- Reset mid-operation: the hold is abandoned with no done pulse.
- All outputs are registered. level and ready are decoded from the registered state.
- States: IDLE, HOLD, COOLDOWN.
- Accepted trigger at edge N:
  - Taken in IDLE, or in HOLD when retrigger_en=1.
  - remaining <= (hold_ticks==0 ? HOLD_TICKS : hold_ticks).
  - Prescaler is synchronously cleared; state <= HOLD.
  - level=1 is visible after edge N.
- Tick: prescaler counts 0..DIV-1 and asserts tick in the cycle it holds DIV-1. Each tick in HOLD or COOLDOWN decrements remaining.
- Latency: with no retrigger or cancel, level is high for exactly H*DIV cycles (H = loaded count).
- HOLD expiry (tick while remaining==1):
  - level <= 0, done <= 1 for one cycle.
  - If GUARD_TICKS>0: remaining <= GUARD_TICKS, state <= COOLDOWN.
  - Otherwise: remaining <= 0, state <= IDLE.
- COOLDOWN:
  - level=0, ready=0, triggers are ignored and not queued.
  - Tick while remaining==1 moves to IDLE with remaining <= 0 and no done pulse.
  - cancel in COOLDOWN has no effect.
- trigger in HOLD with retrigger_en=0: ignored.
- cancel in HOLD: state <= IDLE, level <= 0, remaining <= 0. No done pulse, no cooldown.
- Simultaneous events:
  - cancel and trigger in HOLD: cancel wins.
  - cancel and trigger in IDLE: trigger accepted.
  - Expiry tick and trigger with retrigger_en=1: reload wins, no done pulse, level stays 1.
  - Expiry tick and trigger with retrigger_en=0: expiry proceeds and the trigger is dropped.
- The prescaler free-runs in IDLE. Its phase is irrelevant because it is cleared on acceptance.
- DIV==1: tick is asserted every cycle.
- Arithmetic is unsigned CNTBITS. remaining never underflows, since expiry is detected at 1.

Decomposition:
- Shared package util_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN} stretch_state_t;
  - function calc_div(clkfreq, tickfreq) returning the DIV constant. It is also usable by other clock-division users.
- Sub-module tick_gen:
  - Parameters DIV and width $clog2(DIV)+1.
  - Ports clk, reset, clear, tick.
  - Asynchronous reset, synchronous clear.
- The top level holds the FSM and the remaining counter.

Test Plan:
Test bench parameters: CLKFREQ=100, TICKFREQ=10 (DIV=10), HOLD_TICKS=3, GUARD_TICKS=2, CNTBITS=8.
1. Basic hold: trigger at cycle 5 with hold_ticks=0 -> level high for exactly 30 cycles, done for 1 cycle at the falling edge, then COOLDOWN for 20 cycles with ready=0, then ready=1 and remaining=0.
2. Runtime length: hold_ticks=5 -> level high for 50 cycles. A trigger held for 2 cycles counts as one request in IDLE; the second high cycle in HOLD is ignored when retrigger_en=0.
3. Retrigger at 25 cycles into a hold (retrigger_en=1, hold_ticks=0) -> level high for 25+30=55 cycles total, a single done pulse. Same stimulus with retrigger_en=0 -> level high for 30 cycles.
4. Cancel and trigger together 12 cycles into a hold -> level=0 next cycle, done never asserts, ready=1, no cooldown. A trigger during COOLDOWN is ignored and level stays 0.
5. Expiry tick and trigger in the same cycle with retrigger_en=1 -> level stays 1, no done pulse, remaining=3.
6. Reset asserted between clock edges at 15 cycles into a hold -> level=0, ready=1 and remaining=0 immediately. After release, a trigger yields a fresh 30-cycle hold.
